key_paste_fifo: RTL and testbench
=================================

KEY_PASTE_FIFO -- requirements
Module: key_paste_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter PACE, default 2000, meaning cpu_clken ticks between a KBD read and presentation of the next character.
REQ-003 SHALL have port sys_clock  in  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_clken  in  1  CPU clock enable; CPU reads qualified by it.
REQ-006 SHALL have port host_data  in  8  ASCII byte from host paste/injection source.
REQ-007 SHALL have port host_valid  in  1  host_data valid.
REQ-008 SHALL have port host_ready  out  1  FIFO can accept a byte.
REQ-009 SHALL have port flush  in  1  synchronous discard of all queued and presented data.
REQ-010 SHALL have port cs  in  1  chip select for the 0xD010/0xD011 keyboard window.
REQ-011 SHALL have port address  in  1  0 = KBD (0xD010), 1 = KBDCR (0xD011).
REQ-012 SHALL have port we  in  1  CPU write; writes are ignored.
REQ-013 SHALL have port dout  out  8  read data for the CPU data-in mux.
REQ-014 SHALL have port busy  out  1  FIFO non-empty or a character presented.

Function
REQ-015 SHALL accept a byte when host_valid & host_ready on a sys_clock edge (push).
REQ-016 SHALL drive host_ready = (count < DEPTH).
REQ-017 SHALL, at push, map 0x61..0x7A to value-0x20, drop 0x0A (not stored), and store all other bytes' bits [6:0] unchanged.
REQ-018 SHALL keep count width clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-019 SHALL, on push and pop in the same cycle, leave count unchanged and perform both.
REQ-020 SHALL ignore a push attempted while full (host_ready low); no overwrite, no count change.
REQ-021 SHALL implement FSM IDLE, PRESENT, PACE.
REQ-022 IDLE: if count>0, pop head into char register, set key_avail=1, go PRESENT next cycle (pop latency 1 sys_clock).
REQ-023 PRESENT: CPU read of KBD (cs & !we & !address & cpu_clken) SHALL clear key_avail, load pace counter with PACE-1, go PACE.
REQ-024 PACE: decrement pace counter on each cpu_clken; at zero with cpu_clken go IDLE; PACE=0 or 1 SHALL yield IDLE after one tick.
REQ-025 SHALL return dout = {1'b1, char[6:0]} when address=0, {key_avail, 7'b0} when address=1, combinationally from registers.
REQ-026 SHALL drive dout = 8'h00 when cs is low.
REQ-027 SHALL NOT change state on KBDCR reads or on any write.
REQ-028 flush SHALL empty FIFO, clear key_avail, go IDLE in one cycle, overriding a simultaneous push and read.
REQ-029 SHALL drive busy = (count != 0) | (state != IDLE).

Reset
REQ-030 While reset low: count=0, pointers=0, state=IDLE, key_avail=0, char=0, pace counter=0.
REQ-031 Outputs during reset: host_ready=1, busy=0, dout per REQ-025/026 from reset registers (KBD read = 8'h80).
REQ-032 Reset asserted mid-PRESENT or mid-PACE SHALL discard queued data; no character presented after release until a new push.

Verification
REQ-033 Push 'a' (0x61), wait 2 cycles, read KBDCR -> 8'h80; read KBD -> 8'hC1; read KBDCR -> 8'h00.
REQ-034 Push "AB", read KBD -> 8'hC1; KBDCR stays 8'h00 for PACE cpu_clken ticks, then 8'h80; KBD -> 8'hC2.
REQ-035 Push 17 bytes with DEPTH=16, no CPU reads -> host_ready low after 16th pop-adjusted fill (first byte presented, 16 queued); 18th push dropped; all 17 read back in order.
REQ-036 Push 0x0D,0x0A,0x0D -> exactly two characters 0x8D, 0x8D delivered.
REQ-037 Fill with 5 bytes, assert flush same cycle as push and KBD read -> count=0, key_avail=0, busy=0, next KBDCR 8'h00.
REQ-038 Pull reset low during PACE with 3 bytes queued -> after release busy=0, host_ready=1, KBDCR 8'h00.

Source files
------------

// File: rtl/key_paste_fifo.sv
// key_paste_fifo
//   Paste/injection queue in front of an Apple-1 style keyboard port.
//   Host bytes are upper-cased, line feeds are dropped, and the result is
//   queued. One character at a time is presented at KBD/KBDCR. After the
//   CPU reads KBD, the next character is held back for PACE cpu_clken ticks.
//
// Ports
//   sys_clock  in   system clock, all state on its rising edge
//   reset      in   asynchronous active-low reset
//   cpu_clken  in   CPU clock enable; qualifies CPU reads and pace ticks
//   host_data  in   [7:0] ASCII byte from the host
//   host_valid in   host_data valid
//   host_ready out  FIFO has room for a byte
//   flush      in   synchronous discard of queued and presented data
//   cs         in   chip select for the KBD/KBDCR window
//   address    in   0 = KBD, 1 = KBDCR
//   we         in   CPU write strobe (writes have no effect)
//   dout       out  [7:0] read data
//   busy       out  queue non-empty or not idle
//
// state   | meaning
// S_IDLE    | nothing presented; pops the head when the queue is non-empty
// S_PRESENT | character held in char_q, key_avail_q set, waiting for a KBD read
// S_PACE    | KBD was read; counting cpu_clken ticks before the next pop
module key_paste_fifo #(
    parameter int DEPTH = 16,
    parameter int PACE  = 2000
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       cpu_clken,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       flush,
    input  logic       cs,
    input  logic       address,
    input  logic       we,
    output logic [7:0] dout,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    // Counter only has to hold PACE-1; PACE of 0 or 1 collapses to a single tick.
    localparam int PW = (PACE > 2) ? $clog2(PACE) : 1;
    localparam logic [PW-1:0] PACE_LOAD = (PACE > 1) ? PW'(PACE - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_PACE    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [6:0]      char_q, char_d;
    logic            key_avail_q, key_avail_d;
    logic [PW-1:0]   pace_cnt_q, pace_cnt_d;
    logic [6:0]      mem_q [DEPTH];

    logic            is_lf;
    logic            is_lower;
    logic [6:0]      wr_data;
    logic            push;
    logic            pop;
    logic            kbd_rd;

    always_comb begin
        host_ready = (count_q < (AW+1)'(DEPTH));
        is_lf      = (host_data == 8'h0A);
        is_lower   = (host_data >= 8'h61) && (host_data <= 8'h7A);
        wr_data    = is_lower ? (host_data[6:0] - 7'h20) : host_data[6:0];
        // Line feeds are consumed from the host but never stored.
        push       = host_valid & host_ready & ~is_lf & ~flush;
        pop        = (state_q == S_IDLE) & (count_q != '0) & ~flush;
        kbd_rd     = cs & ~we & ~address & cpu_clken;
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        char_d      = char_q;
        key_avail_d = key_avail_q;
        pace_cnt_d  = pace_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    char_d      = mem_q[rd_ptr_q];
                    key_avail_d = 1'b1;
                    state_d     = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (kbd_rd) begin
                    key_avail_d = 1'b0;
                    pace_cnt_d  = PACE_LOAD;
                    state_d     = S_PACE;
                end
            end
            S_PACE: begin
                if (cpu_clken) begin
                    if (pace_cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        pace_cnt_d = pace_cnt_q - PW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over any push, pop or read in the same cycle.
        if (flush) begin
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            key_avail_d = 1'b0;
            state_d     = S_IDLE;
        end
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            char_q      <= '0;
            key_avail_q <= 1'b0;
            pace_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            char_q      <= char_d;
            key_avail_q <= key_avail_d;
            pace_cnt_q  <= pace_cnt_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge sys_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign dout = !cs     ? 8'h00 :
                  address ? {key_avail_q, 7'b0} :
                            {1'b1, char_q};

    assign busy = (count_q != '0) | (state_q != S_IDLE);

endmodule

// File: tb/tb_key_paste_fifo.sv
module tb_key_paste_fifo;

    localparam int DEPTH = 16;
    localparam int PACE  = 5;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       cpu_clken;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_ready;
    logic       flush;
    logic       cs;
    logic       address;
    logic       we;
    logic [7:0] dout;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    key_paste_fifo #(.DEPTH(DEPTH), .PACE(PACE)) dut (
        .sys_clock  (sys_clock),
        .reset      (reset),
        .cpu_clken  (cpu_clken),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .flush      (flush),
        .cs         (cs),
        .address    (address),
        .we         (we),
        .dout       (dout),
        .busy       (busy)
    );

    always #5 sys_clock = ~sys_clock;

    // Value the CPU must see at KBD for a byte the host pushed.
    function automatic logic [7:0] exp_kbd(input logic [7:0] b);
        logic [7:0] m;
        m = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
        return {1'b1, m[6:0]};
    endfunction

    task automatic cyc();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic quiet();
        host_valid = 1'b0;
        cs         = 1'b0;
        we         = 1'b0;
        address    = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic rd_kbdcr(output logic [7:0] v);
        cs = 1'b1; address = 1'b1; we = 1'b0;
        #1 v = dout;
        cs = 1'b0; address = 1'b0;
        #1;
    endtask

    task automatic rd_kbd(output logic [7:0] v);
        cs = 1'b1; address = 1'b0; we = 1'b0; cpu_clken = 1'b1;
        #1 v = dout;
        cyc();
        cs = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        host_data = b; host_valid = 1'b1;
        cyc();
        host_valid = 1'b0;
    endtask

    task automatic wait_avail(output bit ok);
        logic [7:0] v;
        ok = 1'b0;
        cpu_clken = 1'b1;
        for (int i = 0; i < 200; i++) begin
            rd_kbdcr(v);
            if (v == 8'h80) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic settle(input int n);
        cpu_clken = 1'b1;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b0; cpu_clken = 1'b0; host_data = 8'h00; quiet();
        cyc(); cyc();
        cs = 1'b1; address = 1'b0; #1;
        n_cmp++; if (dout !== 8'h80) begin n_bad++; $display("FAIL reset_kbd: got %h want 80", dout); end
        address = 1'b1; #1;
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_kbdcr: got %h want 00", dout); end
        cs = 1'b0; #1;
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_cs_low: got %h want 00", dout); end
        n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", host_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        address = 1'b0;
        reset = 1'b1;
        cyc();
        rd_kbdcr(v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL post_reset_kbdcr: got %h want 00", v); end
    endtask

    task automatic test_single();
        logic [7:0] v;
        cpu_clken = 1'b0;
        push_byte(8'h61);
        cyc(); cyc();
        rd_kbdcr(v);
        n_cmp++; if (v !== 8'h80) begin n_bad++; $display("FAIL single_kbdcr_set: got %h want 80", v); end
        rd_kbd(v);
        n_cmp++; if (v !== 8'hC1) begin n_bad++; $display("FAIL single_kbd: got %h want C1", v); end
        rd_kbdcr(v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL single_kbdcr_clr: got %h want 00", v); end
        settle(PACE + 4);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_pace();
        logic [7:0] v;
        bit ok, idle_seen, shown, done;
        int remaining;
        push_byte(8'h41);
        push_byte(8'h42);
        wait_avail(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL pace_first_avail: got timeout want 80"); end
        rd_kbd(v);
        n_cmp++; if (v !== 8'hC1) begin n_bad++; $display("FAIL pace_first_kbd: got %h want C1", v); end
        remaining = PACE; idle_seen = 0; shown = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            rd_kbdcr(v);
            n_cmp++;
            if (v !== (shown ? 8'h80 : 8'h00)) begin
                n_bad++;
                $display("FAIL pace_kbdcr cycle %0d: got %h want %h", i, v, shown ? 8'h80 : 8'h00);
            end
            if (shown) begin
                done = 1;
            end else begin
                cpu_clken = ($urandom_range(0, 1) == 1);
                if (idle_seen) shown = 1;
                else if (cpu_clken) begin
                    remaining--;
                    if (remaining == 0) idle_seen = 1;
                end
                cyc();
            end
        end
        n_cmp++; if (!done) begin n_bad++; $display("FAIL pace_timeout: got no second char want C2"); end
        rd_kbd(v);
        n_cmp++; if (v !== 8'hC2) begin n_bad++; $display("FAIL pace_second_kbd: got %h want C2", v); end
        settle(PACE + 4);
    endtask

    task automatic test_full();
        logic [7:0] bytes [17];
        logic [7:0] v;
        bit ok;
        for (int i = 0; i < 17; i++) begin
            do bytes[i] = 8'($urandom); while (bytes[i] == 8'h0A);
        end
        for (int i = 0; i < 17; i++) begin
            cpu_clken = ($urandom_range(0, 1) == 1);
            n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_before_%0d: got %b want 1", i, host_ready); end
            push_byte(bytes[i]);
        end
        n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_low: got %b want 0", host_ready); end
        push_byte(8'h5A);
        n_cmp++; if (host_ready !== 1'b0) begin n_bad++; $display("FAIL full_after_drop: got %b want 0", host_ready); end
        for (int i = 0; i < 17; i++) begin
            wait_avail(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_avail_%0d: got timeout want 80", i); end
            rd_kbd(v);
            n_cmp++; if (v !== exp_kbd(bytes[i])) begin n_bad++; $display("FAIL full_read_%0d: got %h want %h", i, v, exp_kbd(bytes[i])); end
        end
        settle(PACE + 4);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_drain_busy: got %b want 0", busy); end
    endtask

    task automatic test_lf();
        logic [7:0] v;
        bit ok;
        push_byte(8'h0D);
        push_byte(8'h0A);
        push_byte(8'h0D);
        for (int i = 0; i < 2; i++) begin
            wait_avail(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL lf_avail_%0d: got timeout want 80", i); end
            rd_kbd(v);
            n_cmp++; if (v !== 8'h8D) begin n_bad++; $display("FAIL lf_read_%0d: got %h want 8D", i, v); end
        end
        settle(PACE + 6);
        rd_kbdcr(v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL lf_no_third: got %h want 00", v); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lf_busy: got %b want 0", busy); end
    endtask

    task automatic test_flush();
        logic [7:0] v;
        for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i));
        cyc();
        host_data = 8'h33; host_valid = 1'b1; flush = 1'b1;
        cs = 1'b1; address = 1'b0; we = 1'b0; cpu_clken = 1'b1;
        cyc();
        quiet();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", host_ready); end
        rd_kbdcr(v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL flush_kbdcr: got %h want 00", v); end
        settle(PACE + 4);
        rd_kbdcr(v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL flush_kbdcr_later: got %h want 00", v); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy_later: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        bit ok;
        for (int i = 0; i < 4; i++) push_byte(8'h70 + 8'(i));
        wait_avail(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_avail: got timeout want 80"); end
        rd_kbd(v);
        n_cmp++; if (v !== exp_kbd(8'h70)) begin n_bad++; $display("FAIL rstmid_read: got %h want %h", v, exp_kbd(8'h70)); end
        cpu_clken = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (host_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", host_ready); end
        settle(PACE + 6);
        rd_kbdcr(v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL rstmid_kbdcr: got %h want 00", v); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_later: got %b want 0", busy); end
    endtask

    // Reference model: exp_q holds every character the CPU has yet to read,
    // including the one currently presented.
    task automatic test_random();
        logic [7:0] exp_q [$];
        logic [7:0] v, b;
        logic       avail, real_rd;
        int         fifo_cnt;
        for (int i = 0; i < 800; i++) begin
            rd_kbdcr(v);
            avail = v[7];
            if (avail) begin
                n_cmp++; if (exp_q.size() == 0) begin n_bad++; $display("FAIL rnd_phantom cycle %0d: got avail want none queued", i); end
            end
            fifo_cnt = exp_q.size() - (avail ? 1 : 0);
            n_cmp++;
            if (host_ready !== (fifo_cnt < DEPTH)) begin
                n_bad++; $display("FAIL rnd_ready cycle %0d: got %b want %b", i, host_ready, fifo_cnt < DEPTH);
            end
            b = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'($urandom);
            host_data  = b;
            host_valid = ($urandom_range(0, 2) == 0);
            cs         = ($urandom_range(0, 1) == 1);
            address    = ($urandom_range(0, 2) == 0);
            we         = ($urandom_range(0, 3) == 0);
            cpu_clken  = ($urandom_range(0, 1) == 1);
            flush      = ($urandom_range(0, 99) == 0);
            real_rd    = cs & ~we & ~address & cpu_clken & avail & ~flush;
            #1;
            if (real_rd && exp_q.size() > 0) begin
                n_cmp++;
                if (dout !== exp_q[0]) begin n_bad++; $display("FAIL rnd_read cycle %0d: got %h want %h", i, dout, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (host_valid && host_ready && b != 8'h0A) exp_q.push_back(exp_kbd(b));
            cyc();
            quiet();
        end
        cpu_clken = 1'b1;
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) begin
            rd_kbdcr(v);
            if (v[7]) begin
                rd_kbd(v);
                n_cmp++;
                if (v !== exp_q[0]) begin n_bad++; $display("FAIL rnd_drain: got %h want %h", v, exp_q[0]); end
                void'(exp_q.pop_front());
            end else begin
                cyc();
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_drain_left: got %0d left want 0", exp_q.size()); end
        settle(PACE + 4);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_final_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pace();
        test_full();
        test_lf();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
